// File: rtl/iomem_fabric.sv
// Address-window decoder between the PicoRV32 native bus and up to 16 peripheral slots.
// Unanswered or unmapped accesses complete with ERR_DATA and latch a sticky error flag.
module iomem_fabric #(
  parameter int unsigned NSLAVES    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned SLOT_SHIFT = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m_valid,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrb,
  output logic                    m_hit,
  output logic                    m_ready,
  output logic [31:0]             m_rdata,
  output logic [NSLAVES-1:0]      s_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic [NSLAVES-1:0]      s_ready,
  input  logic [32*NSLAVES-1:0]   s_rdata,
  output logic                    err_irq,
  output logic [31:0]             err_addr,
  input  logic                    err_clr
);

  // state  | meaning
  // IDLE   | waiting for an in-window request
  // ACCESS | request held toward one slave, timeout running
  // RESP   | one-cycle m_ready strobe with the registered response

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int unsigned HI = SLOT_SHIFT + 4;

  state_t              state_q, state_d;
  logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [3:0]          slot_q, slot_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         resp_q, resp_d;
  logic                err_irq_q, err_irq_d;
  logic [31:0]         err_addr_q, err_addr_d;

  logic                in_win;
  logic [3:0]          m_slot;
  logic                slot_ok;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                err_rec;
  logic [31:0]         err_rec_addr;

  assign in_win  = (m_addr[31:HI] == BASE_ADDR[31:HI]);
  assign m_slot  = m_addr[HI-1:SLOT_SHIFT];
  assign m_hit   = m_valid && in_win;
  assign slot_ok = ({1'b0, m_slot} < 5'(NSLAVES));

  // s_valid_q is one-hot on slot_q, so masking with it ignores foreign readies
  assign sel_ready = |(s_ready & s_valid_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (slot_q == 4'(k)) sel_rdata = s_rdata[32*k +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    s_valid_d    = s_valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    err_rec      = 1'b0;
    err_rec_addr = addr_q;

    unique case (state_q)
      IDLE: begin
        if (m_hit) begin
          if (slot_ok) begin
            addr_d    = m_addr;
            wdata_d   = m_wdata;
            wstrb_d   = m_wstrb;
            slot_d    = m_slot;
            s_valid_d = '0;
            for (int k = 0; k < NSLAVES; k++) begin
              if (m_slot == 4'(k)) s_valid_d[k] = 1'b1;
            end
            // timer counts down from TIMEOUT-1; zero without ready means abort
            cnt_d   = 16'(TIMEOUT - 1);
            state_d = ACCESS;
          end else begin
            resp_d       = ERR_DATA;
            err_rec      = 1'b1;
            err_rec_addr = m_addr;
            state_d      = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          resp_d    = (wstrb_q == 4'd0) ? sel_rdata : 32'd0;
          s_valid_d = '0;
          state_d   = RESP;
        end else if (cnt_q == 16'd0) begin
          resp_d       = ERR_DATA;
          s_valid_d    = '0;
          err_rec      = 1'b1;
          err_rec_addr = addr_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_irq_d  = 1'b0;
      err_addr_d = 32'd0;
    end
    // a fresh error overrides a same-cycle clear
    if (err_rec && (!err_irq_q || err_clr)) begin
      err_irq_d  = 1'b1;
      err_addr_d = err_rec_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      s_valid_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_ready  = (state_q == RESP);
  assign m_rdata  = m_ready ? resp_q : 32'd0;
  assign s_valid  = s_valid_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_iomem_fabric.sv
// Self-checking bench for iomem_fabric: vector table plus scoreboard of expected CPU responses,
// with hand-written sequences for reset, error-clear and out-of-window cases.
module tb_iomem_fabric;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            resetn;
  logic            m_valid;
  logic [31:0]     m_addr, m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_hit, m_ready;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_valid;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_wstrb;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;
  logic            err_irq;
  logic [31:0]     err_addr;
  logic            err_clr;

  iomem_fabric #(
    .NSLAVES(NS), .BASE_ADDR(32'h0300_0000), .SLOT_SHIFT(16),
    .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_hit(m_hit), .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // scoreboard consumer: every m_ready must match the oldest expected response
  always @(negedge clk) begin
    if (resetn) begin
      if (m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_m_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("m_ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("m_rdata", m_rdata, e.data);
        end
      end else if (m_rdata != 32'd0) begin
        chk("m_rdata_idle_zero", m_rdata, 32'd0);
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d;          // s_valid cycle in which the slave answers; 0 = never
    logic [31:0] sdata;
    bit          noise;      // hold ready high on all non-selected slots
    bit          clr_before; // pulse err_clr one idle cycle first
    int          clr_cyc;    // cycle of the transaction to assert err_clr; 0 = none
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                              input int d, input logic [31:0] sd, input bit nz,
                              input bit cb, input int cc);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wstrb = ws; v.d = d; v.sdata = sd;
    v.noise = nz; v.clr_before = cb; v.clr_cyc = cc;
    return v;
  endfunction

  logic        exp_irq = 1'b0;
  logic [31:0] exp_eaddr = 32'd0;

  // entered and left at posedge+1; new request driven immediately (back-to-back after RESP)
  task automatic do_req(input vec_t v);
    logic [3:0]  sl;
    logic [3:0]  oh;
    logic [3:0]  rdy;
    logic [31:0] edata;
    int          lat, last_sv, t0;
    bit          err, done;
    exp_t        e;

    sl = v.addr[19:16];
    oh = (sl < 4'(NS)) ? (4'b0001 << sl) : 4'b0000;
    if (sl >= 4'(NS)) begin
      lat = 1; edata = ERRD; err = 1'b1; last_sv = 0;
    end else if (v.d >= 1 && v.d <= TO) begin
      lat = v.d + 1; edata = (v.wstrb != 4'd0) ? 32'd0 : v.sdata; err = 1'b0; last_sv = v.d;
    end else begin
      lat = TO + 1; edata = ERRD; err = 1'b1; last_sv = TO;
    end

    if (v.clr_before) begin
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      exp_irq = 1'b0; exp_eaddr = 32'd0;
    end

    m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb;
    for (int k = 0; k < NS; k++)
      s_rdata[32*k +: 32] = (4'(k) == sl) ? v.sdata : (32'h5A00_0000 | 32'(k));
    s_ready = v.noise ? ~oh : 4'b0000;
    t0 = cyc;
    e.cyc = t0 + lat; e.data = edata;
    sb.push_back(e);
    #1;
    chk("m_hit_in_window", {31'd0, m_hit}, 32'd1);

    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge clk); #1;
      rdy = v.noise ? ~oh : 4'b0000;
      if (k == v.d) rdy = rdy | oh;
      s_ready = rdy;
      err_clr = (v.clr_cyc != 0 && k == v.clr_cyc);
      @(negedge clk);
      chk("s_valid", {28'd0, s_valid}, {28'd0, (k <= last_sv) ? oh : 4'b0000});
      if (s_valid != '0) begin
        chk("s_addr_stable", s_addr, v.addr);
        chk("s_wdata_stable", s_wdata, v.wdata);
        chk("s_wstrb_stable", {28'd0, s_wstrb}, {28'd0, v.wstrb});
      end
      if (m_ready) done = 1'b1;
    end
    if (!done) chk("m_ready_timeout", 32'd0, 32'd1);

    @(posedge clk); #1;
    m_valid = 1'b0; m_wstrb = 4'd0; s_ready = '0; err_clr = 1'b0;

    if (err) begin
      if (!exp_irq || v.clr_cyc != 0) begin
        exp_irq = 1'b1; exp_eaddr = v.addr;
      end
    end else if (v.clr_cyc != 0) begin
      exp_irq = 1'b0; exp_eaddr = 32'd0;
    end
    chk("err_irq", {31'd0, err_irq}, {31'd0, exp_irq});
    chk("err_addr", err_addr, exp_eaddr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_valid"}, {28'd0, s_valid}, 32'd0);
    chk({tag, "_s_addr"}, s_addr, 32'd0);
    chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    chk({tag, "_s_wstrb"}, {28'd0, s_wstrb}, 32'd0);
    chk({tag, "_m_ready"}, {31'd0, m_ready}, 32'd0);
    chk({tag, "_m_rdata"}, m_rdata, 32'd0);
    chk({tag, "_err_irq"}, {31'd0, err_irq}, 32'd0);
    chk({tag, "_err_addr"}, err_addr, 32'd0);
  endtask

  vec_t vecs[11];
  logic [31:0] oow_addr[2];

  initial begin
    vecs[0]  = mk(32'h0302_0010, 32'h0,         4'b0000, 1, 32'h1234_5678, 0, 0, 0);
    vecs[1]  = mk(32'h0300_0000, 32'hA5A5_A5A5, 4'b0011, 5, 32'h1111_1111, 0, 0, 0);
    vecs[2]  = mk(32'h0303_FFFC, 32'h0,         4'b0000, 3, 32'hCAFE_0003, 1, 0, 0);
    vecs[3]  = mk(32'h0301_0000, 32'h0,         4'b0000, 0, 32'h2222_2222, 0, 0, 0);
    vecs[4]  = mk(32'h0307_0000, 32'h0,         4'b0000, 0, 32'h0,         0, 1, 0);
    vecs[5]  = mk(32'h0303_0040, 32'h0BAD_0BAD, 4'b1111, 0, 32'h3333_3333, 0, 0, 0);
    vecs[6]  = mk(32'h0301_0020, 32'h0,         4'b0000, TO, 32'h8888_0008, 0, 0, 0);
    vecs[7]  = mk(32'h0302_0004, 32'h7700_0000, 4'b1000, 2, 32'h4444_4444, 0, 0, 0);
    vecs[8]  = mk(32'h0300_0004, 32'h0,         4'b0000, 0, 32'h5555_5555, 0, 0, TO);
    vecs[9]  = mk(32'h0301_0008, 32'h0,         4'b0000, 2, 32'h7777_0001, 0, 0, 0);
    vecs[10] = mk(32'h030F_0000, 32'h0,         4'b0000, 0, 32'h0,         0, 0, 0);
    oow_addr[0] = 32'h0310_0000;
    oow_addr[1] = 32'h02FF_FFFC;

    resetn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0; err_clr = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i <= 8; i++) do_req(vecs[i]);

    // asynchronous reset while the request sits in ACCESS
    m_valid = 1'b1; m_addr = 32'h0301_0008; m_wdata = '0; m_wstrb = 4'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_s_valid", {28'd0, s_valid}, 32'h2);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_valid = 1'b0;
    exp_irq = 1'b0; exp_eaddr = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_pending", 32'(sb.size()), 32'd0);

    for (int i = 9; i <= 10; i++) do_req(vecs[i]);

    // lone clear
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("lone_clr_irq", {31'd0, err_irq}, 32'd0);
    chk("lone_clr_addr", err_addr, 32'd0);

    // out-of-window requests are invisible
    for (int a = 0; a < 2; a++) begin
      @(posedge clk); #1;
      m_valid = 1'b1; m_addr = oow_addr[a]; m_wstrb = 4'd0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("oow_m_hit", {31'd0, m_hit}, 32'd0);
        chk("oow_s_valid", {28'd0, s_valid}, 32'd0);
      end
      m_valid = 1'b0;
      chk("oow_err_irq", {31'd0, err_irq}, 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
